// File: rtl/seg7_scan_ctrl.sv
// Scans a packed hex value through one shared seg7 decoder, one digit per two cycles, MSB first.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
`timescale 1ns/1ps
module seg7_scan_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  output logic              ready,
  output logic              busy,
  output logic              done,
  input  logic              blank,
  output logic [3:0]        dec_bnum,
  input  logic [6:0]        dec_led,
  output logic [7*NDIG-1:0] hex
);

  localparam int IW = 3;

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_CAPT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        bnum_q, bnum_d;
  logic [7*NDIG-1:0] hex_q, hex_d;
  logic [3:0]        nib_s;
  logic [6:0]        capt_s;
`ifdef SEG7_LZB_EN
  logic              zrun_q, zrun_d;
`endif

  assign nib_s = shadow_q[4*idx_q +: 4];

`ifdef SEG7_LZB_EN
  // Leading zeros above digit 0 are forced dark while the zero run lasts
  always_comb begin
    capt_s = dec_led;
    if (zrun_q && (nib_s == 4'd0) && (idx_q != {IW{1'b0}})) begin
      capt_s = 7'h7F;
    end else begin
      capt_s = dec_led;
    end
  end
`else
  assign capt_s = dec_led;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    bnum_d   = bnum_q;
    hex_d    = hex_q;
`ifdef SEG7_LZB_EN
    zrun_d   = zrun_q;
`endif
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (load) begin
          state_d  = S_SEL;
          shadow_d = value;
          idx_d    = IW'(NDIG - 1);
`ifdef SEG7_LZB_EN
          zrun_d   = 1'b1;
`endif
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SEL: begin
        busy    = 1'b1;
        bnum_d  = nib_s;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        busy                = 1'b1;
        hex_d[7*idx_q +: 7] = capt_s;
`ifdef SEG7_LZB_EN
        zrun_d              = zrun_q && (nib_s == 4'd0);
`endif
        if (idx_q == {IW{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - {{(IW-1){1'b0}}, 1'b1};
          state_d = S_SEL;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset aborts any scan and re-blanks every digit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= {(4*NDIG){1'b0}};
      idx_q    <= {IW{1'b0}};
      bnum_q   <= 4'd0;
      hex_q    <= {(7*NDIG){1'b1}};
`ifdef SEG7_LZB_EN
      zrun_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      bnum_q   <= bnum_d;
      hex_q    <= hex_d;
`ifdef SEG7_LZB_EN
      zrun_q   <= zrun_d;
`endif
    end
  end

  assign dec_bnum = bnum_q;
  assign hex      = blank ? {(7*NDIG){1'b1}} : hex_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a behavioural seg7 decoder and a scoreboard of expected displays.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic        ready, busy, done;
  logic [3:0]  dec_bnum;
  logic [6:0]  dec_led;
  logic [27:0] hex;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [27:0] exp_q[$];

  seg7_scan_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .ready(ready),
    .busy(busy), .done(done), .blank(blank), .dec_bnum(dec_bnum),
    .dec_led(dec_led), .hex(hex)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b0000001; 4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010; 4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100; 4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000; 4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000; 4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000; 4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001; 4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000; 4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  assign dec_led = seg(dec_bnum);

  function automatic logic [27:0] model_hex(input logic [15:0] v);
    logic [27:0] r;
    logic        z;
    logic [3:0]  nb;
    r = 28'h0;
    z = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      nb = v[4*d +: 4];
`ifdef SEG7_LZB_EN
      if (z && nb == 4'd0 && d != 0) r[7*d +: 7] = 7'h7F;
      else                           r[7*d +: 7] = seg(nb);
`else
      r[7*d +: 7] = seg(nb);
`endif
      z = z && (nb == 4'd0);
    end
    return r;
  endfunction

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    check("ready_before_accept", {31'd0, ready}, 32'd1);
    exp_q.push_back(model_hex(v));
    tick();
    load = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic pop_cmp(input string tag);
    logic [27:0] e;
    check({tag, "_queue"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {4'd0, hex}, {4'd0, e});
    end
  endtask

  initial begin
    int cyc;
    int d0;
    int rdy_cnt;
    int done_at[$];

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bnum", {28'd0, dec_bnum}, 32'd0);
    check("rst_hex", {4'd0, hex}, 32'h0FFF_FFFF);
    rst = 1'b0;
    tick();

    // 1: basic scan and latency
    d0 = done_cnt;
    start_scan(16'h1234);
    wait_done(cyc);
    check("latency_1234", cyc, 32'd8);
    pop_cmp("hex_1234");
    check("hex_1234_lit", {4'd0, hex}, {4'd0, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
    tick();
    check("ready_after_done", {31'd0, ready}, 32'd1);
    check("done_once_1", done_cnt - d0, 32'd1);

    // 2: loads during a scan are ignored
    d0 = done_cnt;
    start_scan(16'h1234);
    value = 16'hFFFF;
    tick(); tick();
    load = 1'b1;
    check("ready_low_busy", {31'd0, ready}, 32'd0);
    tick();
    load = 1'b0;
    tick(); tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_done(cyc);
    pop_cmp("hex_ignore");
    tick();
    check("done_once_2", done_cnt - d0, 32'd1);
    tick();
    check("no_restart", {31'd0, busy}, 32'd0);

    // 3: reset mid-scan
    d0 = done_cnt;
    start_scan(16'hABCD);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("abort_hex", {4'd0, hex}, 32'h0FFF_FFFF);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    void'(exp_q.pop_back());
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("abort_no_done", done_cnt - d0, 32'd0);
    start_scan(16'hABCD);
    wait_done(cyc);
    pop_cmp("hex_abcd");
    tick();

    // 4: blank masks outputs only
    blank = 1'b1;
    start_scan(16'h00F0);
    tick(); tick(); tick();
    check("blank_mid", {4'd0, hex}, 32'h0FFF_FFFF);
    wait_done(cyc);
    tick();
    check("blank_after", {4'd0, hex}, 32'h0FFF_FFFF);
    blank = 1'b0;
    #1;
    pop_cmp("hex_00f0_unblank");

    // 5: all-zero value
    tick();
    start_scan(16'h0000);
    wait_done(cyc);
`ifdef SEG7_LZB_EN
    check("zero_lzb_lit", {4'd0, hex}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'b0000001});
`else
    check("zero_lit", {4'd0, hex}, {4'd0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001});
`endif
    pop_cmp("hex_0000");
    tick();

    // 6: load held high back to back
    d0 = done_cnt;
    rdy_cnt = 0;
    value = 16'h0001;
    load = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (ready === 1'b1) begin
        rdy_cnt++;
        exp_q.push_back(model_hex(value));
      end
      if (done === 1'b1) begin
        done_at.push_back(i);
        pop_cmp("hex_0001");
      end
      tick();
    end
    load = 1'b0;
    check("b2b_done_cnt", done_cnt - d0, 32'd3);
    check("b2b_ready_cnt", rdy_cnt, 32'd3);
    check("b2b_done_seen", done_at.size(), 32'd3);
    if (done_at.size() == 3) begin
      check("b2b_gap1", done_at[1] - done_at[0], 32'd10);
      check("b2b_gap2", done_at[2] - done_at[1], 32'd10);
    end
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
